hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage RV32IF core (F/D/E/M/W).
- Inspects the decode-stage instruction (the same D_instruction that feeds the immediate extender) against the E stage.
- Drives the PC and pipeline-register enables and flushes for memory freezes, branch/jump redirects, load-use bubbles and CSR serialization.
- Keeps a stall-cycle and a flush counter for performance readout.

Parameters:
CSR_DRAIN, 3, bubble cycles inserted ahead of a CSR instruction (legal 1..15)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
D_instruction  in  32  instruction in the D stage
D_valid  in  1  D stage holds a real instruction
E_valid  in  1  E stage holds a real instruction
E_is_load  in  1  E instruction is LW/LB/LH/LBU/LHU/FLW
E_rd_fp  in  1  E destination is in the FP register file
E_rd  in  5  E destination register index
E_redirect  in  1  E resolved a taken branch, JAL or JALR
I_mem_wait  in  1  instruction memory not ready
M_mem_wait  in  1  data memory not ready
pc_en  out  1  PC update enable
FD_en  out  1  F/D register enable
FD_flush  out  1  F/D register clear
DE_en  out  1  D/E register enable
DE_flush  out  1  D/E register clear (insert bubble)
EM_en  out  1  E/M register enable
MW_en  out  1  M/W register enable
stall_cnt  out  CNT_W  cycles with pc_en=0
flush_cnt  out  CNT_W  accepted redirects

Behaviour:
Source decode from D_instruction[6:0]:
- Integer rs1 read by opcodes 0000011, 0010011, 1100111, 0100011, 1100011, 0110011, 0000111, 0100111.
- Integer rs1 also read by 1110011 when funct3[2]=0.
- Integer rs2 read by 0100011, 1100011, 0110011.
- FP rs2 read by 0100111.
- FP rs1/rs2 read by 1010011.
- Any other opcode reads nothing.

Load-use hazard (lu) requires all of:
- D_valid, E_valid, E_is_load.
- A used source matches E_rd in the same register file (E_rd_fp selects the file).
- An integer match with E_rd=0 is ignored. f0 is a real register.

Outputs are combinational from state and inputs. Priority, highest first:
1. freeze (I_mem_wait | M_mem_wait): all seven outputs 0, state and drain counter hold.
2. E_redirect: pc_en=1, FD_flush=1, DE_flush=1; all other enables 1. State goes to RUN, drain counter cleared. Overrides lu and CSR handling.
3. lu (RUN only): pc_en=0, FD_en=0, DE_flush=1, EM_en=MW_en=1. Exactly one bubble; the next cycle E no longer holds the load.
4. Default: all enables 1, flushes 0.

State machine (2-bit), states RUN, DRAIN, ISSUE; reset state RUN, drain counter 0:
- RUN -> DRAIN: D_valid & opcode=1110011 & no freeze/redirect/lu. On this cycle apply DRAIN outputs and load counter = CSR_DRAIN-1.
- DRAIN outputs: pc_en=0, FD_en=0, DE_flush=1, EM_en=MW_en=1.
- DRAIN transitions: counter decrements on each non-frozen cycle. When it is 0 and the cycle is not frozen, go to ISSUE.
- ISSUE: default outputs (CSR advances into E), then RUN. No CSR or lu check in ISSUE.
- A redirect in DRAIN or ISSUE flushes the CSR and returns to RUN.

Counters:
- stall_cnt increments on every cycle with pc_en=0, freeze included.
- flush_cnt increments on every non-frozen cycle with E_redirect=1.
- Both wrap at 2^CNT_W and reset to 0.

Reset:
- rst_n low clears state, drain counter and both counters immediately.
- Mid-drain reset abandons the drain; no residual stall after release.
- Out of reset with D_valid=0: all enables 1, flushes 0.

Test Plan:
- Reset then idle: D_valid=0 -> pc_en=FD_en=DE_en=EM_en=MW_en=1, FD_flush=DE_flush=0, stall_cnt=0, flush_cnt=0.
- Integer load-use: E=LW x5 (E_is_load=1, E_rd=5, E_rd_fp=0), D=ADD x6,x5,x1 (0x00128333) -> one cycle pc_en=0, FD_en=0, DE_flush=1; next cycle with E_valid=0, default outputs; stall_cnt=1.
- No false hazards:
  - E_rd=0 with D reading x0 -> no stall.
  - E=FLW f5 (E_rd_fp=1), D=ADD reading x5 -> no stall.
  - E=FLW f5, D=FSW f5 (opcode 0100111, rs2=5) -> one-cycle stall.
- CSR drain with default CSR_DRAIN=3:
  - D=CSRRW (0x30029073) -> 3 cycles pc_en=0 / DE_flush=1, then 1 ISSUE cycle with all enables 1, then RUN; stall_cnt=3.
  - M_mem_wait=1 for 2 cycles mid-drain -> drain lasts 5 cycles total, all outputs 0 during the wait.
- Priority:
  - E_redirect=1 together with a load-use hazard -> FD_flush=DE_flush=1, pc_en=1, flush_cnt increments by 1.
  - Same stimulus with I_mem_wait=1 -> all outputs 0 and flush_cnt unchanged.
- Reset mid-drain: assert rst_n=0 in the 2nd DRAIN cycle -> state RUN, counters 0; after release with D_valid=0 -> default outputs.

Source files
------------

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard and stall controller for the 5-stage RV32IF core
// (F/D/E/M/W). It compares the instruction sitting in D against the
// instruction in E. From that comparison it drives the PC enable and the
// pipeline-register enables and flushes, covering four cases:
//   - memory freezes (instruction or data memory not ready)
//   - branch / jump redirects resolved in E
//   - load-use bubbles (one bubble behind a load whose result D needs)
//   - CSR serialization (drain the pipe ahead of a SYSTEM instruction)
// It also keeps two free-running performance counters.
//
// Parameters:
//   CSR_DRAIN  bubble cycles inserted ahead of a CSR instruction (1..15)
//   CNT_W      width of the performance counters
//
// Ports:
//   clk            clock
//   rst_n          asynchronous reset, active-low
//   D_instruction  instruction in the D stage
//   D_valid        D stage holds a real instruction
//   E_valid        E stage holds a real instruction
//   E_is_load      E instruction is LW/LB/LH/LBU/LHU/FLW
//   E_rd_fp        E destination is in the FP register file
//   E_rd           E destination register index
//   E_redirect     E resolved a taken branch, JAL or JALR
//   I_mem_wait     instruction memory not ready
//   M_mem_wait     data memory not ready
//   pc_en          PC update enable
//   FD_en          F/D register enable
//   FD_flush       F/D register clear
//   DE_en          D/E register enable
//   DE_flush       D/E register clear (inserts a bubble)
//   EM_en          E/M register enable
//   MW_en          M/W register enable
//   stall_cnt      number of cycles with pc_en low
//   flush_cnt      number of accepted redirects
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int CSR_DRAIN = 3,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      D_instruction,
    input  logic             D_valid,
    input  logic             E_valid,
    input  logic             E_is_load,
    input  logic             E_rd_fp,
    input  logic [4:0]       E_rd,
    input  logic             E_redirect,
    input  logic             I_mem_wait,
    input  logic             M_mem_wait,
    output logic             pc_en,
    output logic             FD_en,
    output logic             FD_flush,
    output logic             DE_en,
    output logic             DE_flush,
    output logic             EM_en,
    output logic             MW_en,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Opcodes that matter for source-operand decode
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FLW    = 7'b0000111;
    localparam logic [6:0] OP_FSW    = 7'b0100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FP     = 7'b1010011;

    // The CSR instruction itself consumes the first bubble cycle, so the
    // counter is loaded with one less than the total bubble count.
    localparam logic [3:0]       DRAIN_LOAD = 4'(CSR_DRAIN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        DRAIN = 2'b01,
        ISSUE = 2'b10
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  drain_cnt;
    logic [3:0]  drain_next;

    logic [6:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        funct3_msb;

    logic        rs1_int_used;
    logic        rs2_int_used;
    logic        rs1_fp_used;
    logic        rs2_fp_used;

    logic        int_match;
    logic        fp_match;
    logic        lu;
    logic        freeze;
    logic        csr_start;

    // Only the opcode, source fields and funct3[2] are needed here.
    logic        unused_fields;

    assign opcode        = D_instruction[6:0];
    assign rs1           = D_instruction[19:15];
    assign rs2           = D_instruction[24:20];
    assign funct3_msb    = D_instruction[14];
    assign unused_fields = ^{D_instruction[31:25], D_instruction[13:12],
                             D_instruction[11:7]};

    // Work out which register-file sources the D instruction actually
    // reads. SYSTEM only reads rs1 for the register forms of CSRRW/S/C.
    // The immediate forms (funct3[2]=1) carry a zimm in that field
    // instead of a register index.
    always_comb begin
        rs1_int_used = 1'b0;
        rs2_int_used = 1'b0;
        rs1_fp_used  = 1'b0;
        rs2_fp_used  = 1'b0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR, OP_FLW: begin
                rs1_int_used = 1'b1;
            end
            OP_STORE, OP_BRANCH, OP_REG: begin
                rs1_int_used = 1'b1;
                rs2_int_used = 1'b1;
            end
            OP_FSW: begin
                rs1_int_used = 1'b1;
                rs2_fp_used  = 1'b1;
            end
            OP_SYSTEM: begin
                rs1_int_used = ~funct3_msb;
            end
            OP_FP: begin
                rs1_fp_used = 1'b1;
                rs2_fp_used = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Load-use detection. x0 never carries a loaded value, so an integer
    // match on index 0 is harmless. f0 is an ordinary FP register, so an
    // FP match on index 0 still counts.
    assign int_match = ~E_rd_fp && (E_rd != 5'd0) &&
                       ((rs1_int_used && (rs1 == E_rd)) ||
                        (rs2_int_used && (rs2 == E_rd)));
    assign fp_match  = E_rd_fp &&
                       ((rs1_fp_used && (rs1 == E_rd)) ||
                        (rs2_fp_used && (rs2 == E_rd)));
    assign lu        = D_valid && E_valid && E_is_load && (int_match || fp_match);

    assign freeze    = I_mem_wait || M_mem_wait;
    assign csr_start = D_valid && (opcode == OP_SYSTEM);

    // State register and drain counter. A reset at any point drops
    // an in-progress drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            drain_cnt <= 4'd0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_next;
        end
    end

    // Next-state logic. A freeze holds everything. A redirect always
    // returns to RUN because the CSR (if any) is being flushed. The drain
    // leaves for ISSUE on the non-frozen cycle that takes the counter
    // to zero. With CSR_DRAIN=1 the single bubble is the entry cycle, so
    // RUN goes straight to ISSUE.
    always_comb begin
        state_next = state;
        drain_next = drain_cnt;
        if (freeze) begin
            state_next = state;
            drain_next = drain_cnt;
        end else if (E_redirect) begin
            state_next = RUN;
            drain_next = 4'd0;
        end else begin
            case (state)
                RUN: begin
                    if (!lu && csr_start) begin
                        drain_next = DRAIN_LOAD;
                        state_next = (DRAIN_LOAD == 4'd0) ? ISSUE : DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_cnt <= 4'd1) begin
                        drain_next = 4'd0;
                        state_next = ISSUE;
                    end else begin
                        drain_next = drain_cnt - 4'd1;
                    end
                end
                ISSUE: begin
                    state_next = RUN;
                end
                default: begin
                    state_next = RUN;
                    drain_next = 4'd0;
                end
            endcase
        end
    end

    // Output decode, highest priority first: freeze, redirect, then the
    // state-dependent stall. The bubble pattern (hold PC and F/D, clear
    // D/E, let E/M and M/W drain) serves both load-use and CSR drain.
    // ISSUE lets the CSR move into E with no hazard checks.
    always_comb begin
        pc_en    = 1'b1;
        FD_en    = 1'b1;
        FD_flush = 1'b0;
        DE_en    = 1'b1;
        DE_flush = 1'b0;
        EM_en    = 1'b1;
        MW_en    = 1'b1;
        if (freeze) begin
            pc_en    = 1'b0;
            FD_en    = 1'b0;
            FD_flush = 1'b0;
            DE_en    = 1'b0;
            DE_flush = 1'b0;
            EM_en    = 1'b0;
            MW_en    = 1'b0;
        end else if (E_redirect) begin
            FD_flush = 1'b1;
            DE_flush = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (lu || csr_start) begin
                        pc_en    = 1'b0;
                        FD_en    = 1'b0;
                        DE_flush = 1'b1;
                    end
                end
                DRAIN: begin
                    pc_en    = 1'b0;
                    FD_en    = 1'b0;
                    DE_flush = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Performance counters. Frozen cycles count as stalls because the PC
    // is held. A redirect only counts once the pipe actually moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (!freeze && E_redirect) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Self-checking bench for hazard_ctrl. A reference model tracks two things:
// how many drain bubbles are still owed, and whether the CSR issue slot
// is pending. It also computes the register set each D instruction reads.
// A single compare process checks all outputs and both counters against
// this model on every falling edge. Directed sequences add hand-computed
// literal expectations. After that, a long randomized run follows.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int CSR_DRAIN = 3;
    localparam int CNT_W     = 32;

    // Output vector order: {pc_en, FD_en, FD_flush, DE_en, DE_flush, EM_en, MW_en}
    localparam logic [6:0] O_DEF    = 7'b1101011;
    localparam logic [6:0] O_STALL  = 7'b0001111;
    localparam logic [6:0] O_REDIR  = 7'b1111111;
    localparam logic [6:0] O_FROZEN = 7'b0000000;

    localparam logic [31:0] I_ADD_X5  = 32'h00128333;
    localparam logic [31:0] I_ADD_X0  = 32'h00000333;
    localparam logic [31:0] I_FSW_F5  = 32'h00512027;
    localparam logic [31:0] I_CSRRW   = 32'h30029073;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [31:0]      D_instruction = 32'h0;
    logic             D_valid = 1'b0;
    logic             E_valid = 1'b0;
    logic             E_is_load = 1'b0;
    logic             E_rd_fp = 1'b0;
    logic [4:0]       E_rd = 5'd0;
    logic             E_redirect = 1'b0;
    logic             I_mem_wait = 1'b0;
    logic             M_mem_wait = 1'b0;
    logic             pc_en, FD_en, FD_flush, DE_en, DE_flush, EM_en, MW_en;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    // Model state
    int          m_drain = 0;
    bit          m_issue = 1'b0;
    logic [31:0] m_stall = 32'd0;
    logic [31:0] m_flush = 32'd0;

    hazard_ctrl #(.CSR_DRAIN(CSR_DRAIN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .D_instruction(D_instruction),
        .D_valid(D_valid), .E_valid(E_valid), .E_is_load(E_is_load),
        .E_rd_fp(E_rd_fp), .E_rd(E_rd), .E_redirect(E_redirect),
        .I_mem_wait(I_mem_wait), .M_mem_wait(M_mem_wait),
        .pc_en(pc_en), .FD_en(FD_en), .FD_flush(FD_flush), .DE_en(DE_en),
        .DE_flush(DE_flush), .EM_en(EM_en), .MW_en(MW_en),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // Set of registers read by an instruction: bits 0..31 are x0..x31 and
    // bits 32..63 are f0..f31.
    function automatic logic [63:0] read_set(input logic [31:0] ins);
        logic [63:0] s;
        logic [4:0]  r1, r2;
        s  = '0;
        r1 = ins[19:15];
        r2 = ins[24:20];
        case (ins[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b0000111: s[{1'b0, r1}] = 1'b1;
            7'b0100011, 7'b1100011, 7'b0110011: begin
                s[{1'b0, r1}] = 1'b1;
                s[{1'b0, r2}] = 1'b1;
            end
            7'b0100111: begin
                s[{1'b0, r1}] = 1'b1;
                s[{1'b1, r2}] = 1'b1;
            end
            7'b1110011: if (!ins[14]) s[{1'b0, r1}] = 1'b1;
            7'b1010011: begin
                s[{1'b1, r1}] = 1'b1;
                s[{1'b1, r2}] = 1'b1;
            end
            default: ;
        endcase
        return s;
    endfunction

    function automatic bit model_lu();
        logic [63:0] s;
        s = read_set(D_instruction);
        if (!(D_valid && E_valid && E_is_load)) return 1'b0;
        if (!E_rd_fp && E_rd == 5'd0) return 1'b0;
        return s[{E_rd_fp, E_rd}];
    endfunction

    function automatic bit model_csr();
        return D_valid && (D_instruction[6:0] == 7'b1110011);
    endfunction

    function automatic logic [6:0] model_out();
        if (I_mem_wait || M_mem_wait) return O_FROZEN;
        if (E_redirect)               return O_REDIR;
        if (m_drain > 0)              return O_STALL;
        if (m_issue)                  return O_DEF;
        if (model_lu() || model_csr()) return O_STALL;
        return O_DEF;
    endfunction

    // Model advance at each rising edge, async clear on reset.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_drain = 0;
                m_issue = 1'b0;
                m_stall = 32'd0;
                m_flush = 32'd0;
            end else begin
                logic [6:0] o;
                o = model_out();
                if (!o[6]) m_stall = m_stall + 32'd1;
                if (I_mem_wait || M_mem_wait) begin
                end else if (E_redirect) begin
                    m_flush = m_flush + 32'd1;
                    m_drain = 0;
                    m_issue = 1'b0;
                end else if (m_drain > 0) begin
                    m_drain = m_drain - 1;
                    if (m_drain == 0) m_issue = 1'b1;
                end else if (m_issue) begin
                    m_issue = 1'b0;
                end else if (!model_lu() && model_csr()) begin
                    m_drain = CSR_DRAIN - 1;
                    if (m_drain == 0) m_issue = 1'b1;
                end
            end
        end
    end

    // Compare process: every falling edge, outputs and counters vs model.
    initial begin
        forever begin
            logic [6:0] exp_o, act_o;
            @(negedge clk);
            exp_o = model_out();
            act_o = {pc_en, FD_en, FD_flush, DE_en, DE_flush, EM_en, MW_en};
            checks++;
            if (act_o !== exp_o) begin
                errors++;
                $display("[TB] FAIL model_outputs t=%0t got %b expected %b", $time, act_o, exp_o);
            end
            checks++;
            if (stall_cnt !== m_stall) begin
                errors++;
                $display("[TB] FAIL model_stall_cnt t=%0t got %0d expected %0d", $time, stall_cnt, m_stall);
            end
            checks++;
            if (flush_cnt !== m_flush) begin
                errors++;
                $display("[TB] FAIL model_flush_cnt t=%0t got %0d expected %0d", $time, flush_cnt, m_flush);
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] ins, input logic dv, input logic ev,
                                 input logic eld, input logic efp, input logic [4:0] erd,
                                 input logic redir, input logic iw, input logic mw);
        D_instruction = ins;
        D_valid       = dv;
        E_valid       = ev;
        E_is_load     = eld;
        E_rd_fp       = efp;
        E_rd          = erd;
        E_redirect    = redir;
        I_mem_wait    = iw;
        M_mem_wait    = mw;
    endtask

    task automatic checkOutput(input string name, input logic [6:0] exp_o);
        logic [6:0] act_o;
        act_o = {pc_en, FD_en, FD_flush, DE_en, DE_flush, EM_en, MW_en};
        checks++;
        if (act_o !== exp_o) begin
            errors++;
            $display("[TB] FAIL %s outputs got %b expected %b", name, act_o, exp_o);
        end
    endtask

    task automatic checkCounters(input string name, input logic [31:0] exp_s, input logic [31:0] exp_f);
        checks++;
        if (stall_cnt !== exp_s || flush_cnt !== exp_f) begin
            errors++;
            $display("[TB] FAIL %s counters got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                     name, stall_cnt, flush_cnt, exp_s, exp_f);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // One directed cycle: drive, check at the falling edge, move on.
    task automatic directed(input string name, input logic [31:0] ins, input logic dv,
                            input logic ev, input logic eld, input logic efp,
                            input logic [4:0] erd, input logic redir, input logic iw,
                            input logic mw, input logic [6:0] exp_o);
        applyStimulus(ins, dv, ev, eld, efp, erd, redir, iw, mw);
        @(negedge clk);
        checkOutput(name, exp_o);
        nextCycle();
    endtask

    initial begin
        // Reset then idle
        applyStimulus(32'h0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_idle", O_DEF);
        checkCounters("reset_idle", 32'd0, 32'd0);
        nextCycle();

        // Integer load-use: one bubble, then the load has moved on
        directed("lu_int", I_ADD_X5, 1, 1, 1, 0, 5'd5, 0, 0, 0, O_STALL);
        applyStimulus(I_ADD_X5, 1, 0, 0, 0, 5'd5, 0, 0, 0);
        @(negedge clk);
        checkOutput("lu_int_after", O_DEF);
        checkCounters("lu_int_after", 32'd1, 32'd0);
        nextCycle();

        // No false hazards
        directed("lu_x0", I_ADD_X0, 1, 1, 1, 0, 5'd0, 0, 0, 0, O_DEF);
        directed("lu_fp_vs_int", I_ADD_X5, 1, 1, 1, 1, 5'd5, 0, 0, 0, O_DEF);
        directed("lu_fsw_f5", I_FSW_F5, 1, 1, 1, 1, 5'd5, 0, 0, 0, O_STALL);
        directed("lu_fsw_after", I_FSW_F5, 1, 0, 0, 1, 5'd5, 0, 0, 0, O_DEF);

        // CSR drain: three bubbles, then the issue cycle
        for (int i = 0; i < 3; i++)
            directed("csr_drain", I_CSRRW, 1, 0, 0, 0, 5'd0, 0, 0, 0, O_STALL);
        applyStimulus(I_CSRRW, 1, 0, 0, 0, 5'd0, 0, 0, 0);
        @(negedge clk);
        checkOutput("csr_issue", O_DEF);
        checkCounters("csr_issue", 32'd5, 32'd0);
        nextCycle();
        directed("csr_run", 32'h0, 0, 0, 0, 0, 5'd0, 0, 0, 0, O_DEF);

        // CSR drain with a two-cycle data-memory freeze in the middle
        directed("csr_fz_1", I_CSRRW, 1, 0, 0, 0, 5'd0, 0, 0, 0, O_STALL);
        directed("csr_fz_2", I_CSRRW, 1, 0, 0, 0, 5'd0, 0, 0, 0, O_STALL);
        directed("csr_fz_3", I_CSRRW, 1, 0, 0, 0, 5'd0, 0, 0, 1, O_FROZEN);
        directed("csr_fz_4", I_CSRRW, 1, 0, 0, 0, 5'd0, 0, 0, 1, O_FROZEN);
        directed("csr_fz_5", I_CSRRW, 1, 0, 0, 0, 5'd0, 0, 0, 0, O_STALL);
        applyStimulus(I_CSRRW, 1, 0, 0, 0, 5'd0, 0, 0, 0);
        @(negedge clk);
        checkOutput("csr_fz_issue", O_DEF);
        checkCounters("csr_fz_issue", 32'd10, 32'd0);
        nextCycle();

        // Redirect beats load-use; a freeze beats the redirect
        directed("prio_redirect", I_ADD_X5, 1, 1, 1, 0, 5'd5, 1, 0, 0, O_REDIR);
        applyStimulus(32'h0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
        @(negedge clk);
        checkCounters("prio_redirect_cnt", 32'd10, 32'd1);
        nextCycle();
        directed("prio_freeze", I_ADD_X5, 1, 1, 1, 0, 5'd5, 1, 1, 0, O_FROZEN);
        applyStimulus(32'h0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
        @(negedge clk);
        checkCounters("prio_freeze_cnt", 32'd11, 32'd1);
        nextCycle();

        // Reset during the second drain cycle
        directed("rst_drain_1", I_CSRRW, 1, 0, 0, 0, 5'd0, 0, 0, 0, O_STALL);
        applyStimulus(I_CSRRW, 1, 0, 0, 0, 5'd0, 0, 0, 0);
        @(negedge clk);
        checkOutput("rst_drain_2", O_STALL);
        #1;
        rst_n = 1'b0;
        applyStimulus(32'h0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
        #1;
        checkCounters("rst_drain_cleared", 32'd0, 32'd0);
        checkOutput("rst_drain_in_reset", O_DEF);
        nextCycle();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_release_1", O_DEF);
        checkCounters("rst_release_1", 32'd0, 32'd0);
        nextCycle();
        directed("rst_release_2", 32'h0, 0, 0, 0, 0, 5'd0, 0, 0, 0, O_DEF);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            logic [31:0] ins;
            ins = $urandom;
            case ($urandom_range(0, 11))
                0:  ins[6:0] = 7'b0000011;
                1:  ins[6:0] = 7'b0010011;
                2:  ins[6:0] = 7'b1100111;
                3:  ins[6:0] = 7'b0100011;
                4:  ins[6:0] = 7'b1100011;
                5:  ins[6:0] = 7'b0110011;
                6:  ins[6:0] = 7'b0000111;
                7:  ins[6:0] = 7'b0100111;
                8:  ins[6:0] = 7'b1110011;
                9:  ins[6:0] = 7'b1010011;
                10: ins[6:0] = 7'b0110111;
                default: ins[6:0] = 7'b1101111;
            endcase
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[24:20] = 5'($urandom_range(0, 3));
            rst_n = ($urandom_range(0, 299) != 0);
            applyStimulus(ins,
                          $urandom_range(0, 9) < 8,
                          $urandom_range(0, 9) < 7,
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 9) < 3,
                          5'($urandom_range(0, 3)),
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 99) < 8,
                          $urandom_range(0, 99) < 8);
            nextCycle();
        end

        rst_n = 1'b1;
        applyStimulus(32'h0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
